pipe_alu_fwd: RTL



---
 rtl/pipe_alu_pkg.sv | 64 ++++++
 rtl/pipe_alu_fwd_if.sv | 40 ++++
 rtl/pipe_alu_exec.sv | 44 ++++
 rtl/pipe_alu_fwd.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pipe_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_alu_pkg
// Purpose  : Shared operation codes and the ALU function used by the
//            pipe_alu_fwd execute stage.
// Contents : alu_func_e  - 4-bit operation encoding
//            alu_op()    - width-generic ALU evaluated at ALU_MAX_W bits;
//                          callers keep the low data_w bits of the result.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_alu_pkg;

    localparam int ALU_MAX_W = 64;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_MUL  = 4'd2,
        FN_SELA = 4'd3,
        FN_SELB = 4'd4,
        FN_AND  = 4'd5,
        FN_OR   = 4'd6,
        FN_XOR  = 4'd7,
        FN_NEGA = 4'd8,
        FN_NEGB = 4'd9,
        FN_SRA  = 4'd10,
        FN_SLA  = 4'd11
    } alu_func_e;

    // Operands arrive zero-extended; every operation is correct modulo
    // 2^data_w in its low bits, so the caller simply truncates.
    function automatic logic [ALU_MAX_W-1:0] alu_op(
        input logic [3:0]           func,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input int unsigned          data_w
    );
        logic [ALU_MAX_W-1:0] a_sx;
        logic [ALU_MAX_W-1:0] res;
        int unsigned          pad;
        pad  = ALU_MAX_W - data_w;
        // Sign-extend A from bit data_w-1 so the arithmetic right shift
        // pulls the operand's own sign bit into the top result bit.
        a_sx = $signed(a << pad) >>> pad;
        case (func)
            FN_ADD:  res = a + b;
            FN_SUB:  res = a - b;
            FN_MUL:  res = a * b;
            FN_SELA: res = a;
            FN_SELB: res = b;
            FN_AND:  res = a & b;
            FN_OR:   res = a | b;
            FN_XOR:  res = a ^ b;
            FN_NEGA: res = -a;
            FN_NEGB: res = -b;
            FN_SRA:  res = a_sx >> 1;
            FN_SLA:  res = a << 1;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_alu_fwd_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_alu_fwd_if
// Purpose  : Instruction / result / debug read-back bundle of pipe_alu_fwd.
// Ports    : in_valid, rs1, rs2, rd, func, addr  - instruction (master -> slave)
//            z, z_valid, z_addr                  - memory write (slave -> master)
//            dbg_addr / dbg_data                 - registered memory read-back
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_alu_fwd_if #(
    parameter int DATA_W    = 16,
    parameter int NREG      = 16,
    parameter int MEM_DEPTH = 256
);
    localparam int RA_W = $clog2(NREG);
    localparam int MA_W = $clog2(MEM_DEPTH);

    logic              in_valid;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic [3:0]        func;
    logic [MA_W-1:0]   addr;
    logic [DATA_W-1:0] z;
    logic              z_valid;
    logic [MA_W-1:0]   z_addr;
    logic [MA_W-1:0]   dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output in_valid, rs1, rs2, rd, func, addr, dbg_addr,
        input  z, z_valid, z_addr, dbg_data
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, func, addr, dbg_addr,
        output z, z_valid, z_addr, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : pipe_alu_exec
// Purpose  : Combinational execute stage: distance-1 operand bypass from the
//            S2 result register followed by the ALU.
// Ports    : func_i, a_i, b_i, rs1_i, rs2_i     - S1 operands and their tags
//            fwd_valid_i, fwd_rd_i, fwd_data_i - S2 result available to bypass
//            result_o                          - ALU result (next S2 value)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_alu_exec
    import pipe_alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4
) (
    input  wire logic [3:0]        func_i,
    input  wire logic [DATA_W-1:0] a_i,
    input  wire logic [DATA_W-1:0] b_i,
    input  wire logic [RA_W-1:0]   rs1_i,
    input  wire logic [RA_W-1:0]   rs2_i,
    input  wire logic              fwd_valid_i,
    input  wire logic [RA_W-1:0]   fwd_rd_i,
    input  wire logic [DATA_W-1:0] fwd_data_i,
    output logic      [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0] a_fwd;
    logic [DATA_W-1:0] b_fwd;

    // The instruction one ahead has not reached the regbank yet; its result
    // sits in S2 and replaces any operand it produces. Bubbles carry no
    // valid bit and therefore never match.
    always_comb begin
        a_fwd = (fwd_valid_i && (fwd_rd_i == rs1_i)) ? fwd_data_i : a_i;
        b_fwd = (fwd_valid_i && (fwd_rd_i == rs2_i)) ? fwd_data_i : b_i;
    end

    always_comb begin
        result_o = DATA_W'(alu_op(func_i, ALU_MAX_W'(a_fwd), ALU_MAX_W'(b_fwd), DATA_W));
    end

endmodule
`default_nettype wire

// File: rtl/pipe_alu_fwd.sv
`default_nettype none
// ============================================================================
// Module   : pipe_alu_fwd
// Purpose  : Four-stage pipelined ALU (read, execute, writeback, memory write)
//            over a register bank and data memory, with full operand
//            forwarding so dependent instructions issue back to back.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - pipe_alu_fwd_if.slave: instruction in, memory write
//                   result out, registered debug read-back of mem
// Revision : 1.0 - initial release
// ============================================================================
module pipe_alu_fwd
    import pipe_alu_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NREG      = 16,
    parameter int MEM_DEPTH = 256
) (
    input wire logic      clk,
    input wire logic      rst,
    pipe_alu_fwd_if.slave bus
);

    localparam int RA_W = $clog2(NREG);
    localparam int MA_W = $clog2(MEM_DEPTH);

    // Storage (not reset; names are relied on for hierarchical preload)
    logic [DATA_W-1:0] regbank [NREG];
    logic [DATA_W-1:0] mem     [MEM_DEPTH];

    // S1: read
    logic              v1_q;
    logic [DATA_W-1:0] a1_q, a1_d;
    logic [DATA_W-1:0] b1_q, b1_d;
    logic [RA_W-1:0]   rs1_1_q, rs2_1_q, rd1_q;
    logic [3:0]        func1_q;
    logic [MA_W-1:0]   addr1_q;

    // S2: execute
    logic              v2_q;
    logic [DATA_W-1:0] r2_q, r2_d;
    logic [RA_W-1:0]   rd2_q;
    logic [MA_W-1:0]   addr2_q;

    // S3: writeback
    logic              v3_q;
    logic [DATA_W-1:0] r3_q;
    logic [MA_W-1:0]   addr3_q;

    // S4: memory / outputs
    logic              z_valid_q;
    logic [DATA_W-1:0] z_q;
    logic [MA_W-1:0]   z_addr_q;
    logic [DATA_W-1:0] dbg_q;

    // Read bypass: the instruction two ahead writes the regbank on this very
    // edge, so the array still holds the stale value; take it from S2.
    always_comb begin
        a1_d = (v2_q && (rd2_q == bus.rs1)) ? r2_q : regbank[bus.rs1];
        b1_d = (v2_q && (rd2_q == bus.rs2)) ? r2_q : regbank[bus.rs2];
    end

    pipe_alu_exec #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_exec (
        .func_i      (func1_q),
        .a_i         (a1_q),
        .b_i         (b1_q),
        .rs1_i       (rs1_1_q),
        .rs2_i       (rs2_1_q),
        .fwd_valid_i (v2_q),
        .fwd_rd_i    (rd2_q),
        .fwd_data_i  (r2_q),
        .result_o    (r2_d)
    );

    // Valid bits and visible outputs: cleared immediately by reset so that
    // no in-flight instruction can write after rst asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            z_valid_q <= 1'b0;
            z_q       <= '0;
            z_addr_q  <= '0;
            dbg_q     <= '0;
        end else begin
            v1_q      <= bus.in_valid;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            z_valid_q <= v3_q;
            z_q       <= r3_q;
            z_addr_q  <= addr3_q;
            // Non-blocking read: a same-edge S4 write returns the old word.
            dbg_q     <= mem[bus.dbg_addr];
        end
    end

    // Payload registers: meaningful only alongside their valid bit.
    always_ff @(posedge clk) begin
        a1_q    <= a1_d;
        b1_q    <= b1_d;
        rs1_1_q <= bus.rs1;
        rs2_1_q <= bus.rs2;
        rd1_q   <= bus.rd;
        func1_q <= bus.func;
        addr1_q <= bus.addr;
        r2_q    <= r2_d;
        rd2_q   <= rd1_q;
        addr2_q <= addr1_q;
        r3_q    <= r2_q;
        addr3_q <= addr2_q;
    end

    always_ff @(posedge clk) begin
        if (v2_q) begin
            regbank[rd2_q] <= r2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (v3_q) begin
            mem[addr3_q] <= r3_q;
        end
    end

    assign bus.z        = z_q;
    assign bus.z_valid  = z_valid_q;
    assign bus.z_addr   = z_addr_q;
    assign bus.dbg_data = dbg_q;

endmodule
`default_nettype wire
